// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and constants for the RTC time-set controller.
//   rtc_state_e    : controller FSM states
//   HR_MAX/MS_MAX  : BCD wrap limits for hours and minutes/seconds
//   DIGIT_W/FIELD_W: BCD digit and two-digit field widths
//   *_LSB          : field positions in the 24-bit {hr,min,sec} BCD word
//   normalize_time : clamps an arbitrary time word to a legal one
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } rtc_state_e;

  localparam int DIGIT_W = 4;
  localparam int FIELD_W = 2 * DIGIT_W;

  localparam logic [FIELD_W-1:0] HR_MAX = 8'h23;
  localparam logic [FIELD_W-1:0] MS_MAX = 8'h59;

  localparam int HR_LSB  = 16;
  localparam int MIN_LSB = 8;
  localparam int SEC_LSB = 0;

  // A field with a non-decimal digit or a value past its limit becomes 00.
  // Plain magnitude compare is valid once both digits are known to be <= 9.
  function automatic logic [FIELD_W-1:0] norm_field(input logic [FIELD_W-1:0] f,
                                                    input logic [FIELD_W-1:0] max);
    if ((f[7:4] > 4'd9) || (f[3:0] > 4'd9) || (f > max)) return '0;
    return f;
  endfunction

  function automatic logic [23:0] normalize_time(input logic [23:0] t);
    return {norm_field(t[HR_LSB  +: FIELD_W], HR_MAX),
            norm_field(t[MIN_LSB +: FIELD_W], MS_MAX),
            norm_field(t[SEC_LSB +: FIELD_W], MS_MAX)};
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// bcd_field_step: combinational +1/-1 on a two-digit BCD field with wrap.
//   field  : current BCD value
//   max    : largest legal value (wraps max->00 on inc, 00->max on dec)
//   inc    : increment request
//   dec    : decrement request (inc and dec together leave the field alone)
//   result : stepped field
import rtc_pkg::*;

module bcd_field_step (
  input  logic [FIELD_W-1:0] field,
  input  logic [FIELD_W-1:0] max,
  input  logic               inc,
  input  logic               dec,
  output logic [FIELD_W-1:0] result
);

  always_comb begin
    result = field;
    if (inc && !dec) begin
      if (field >= max)              result = '0;
      else if (field[3:0] == 4'd9)   result = {field[7:4] + 4'd1, 4'd0};
      else                           result = {field[7:4], field[3:0] + 4'd1};
    end else if (dec && !inc) begin
      if ((field == '0) || (field > max)) result = max;
      else if (field[3:0] == 4'd0)        result = {field[7:4] - 4'd1, 4'd9};
      else                                result = {field[7:4], field[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/rtc_time_set_ctrl.sv
// rtc_time_set_ctrl: button-driven time-set controller for a BCD RTC.
//   clk, reset    : system clock, asynchronous active-high reset
//   tick_1hz      : one-cycle pulse per second (blink and timeout base)
//   btn_mode      : enter set mode / advance field (hr -> min -> sec -> commit)
//   btn_inc/dec   : step the selected field with BCD wrap
//   cur_time      : live RTC time {hr,min,sec} BCD
//   ld_time       : shadow time; follows cur_time (1-cycle latency) in RUN
//   load          : one-cycle strobe telling the RTC to copy ld_time
//   setting       : high in every state except RUN
//   blink_mask    : {hr,min,sec} visibility, selected field follows blink phase
//   state_dbg     : current FSM state
// Optional build macro RTC_SET_TIMEOUT_EN: leave set mode without loading
// after TIMEOUT_TICKS seconds with no button activity.
import rtc_pkg::*;

module rtc_time_set_ctrl #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic [23:0] ld_time,
  output logic        load,
  output logic        setting,
  output logic [2:0]  blink_mask,
  output rtc_state_e  state_dbg
);

  rtc_state_e         state;
  logic [23:0]        shadow;
  logic               blink_ph;
  logic               inc_eff, dec_eff;
  logic [FIELD_W-1:0] field_cur, field_max, field_new;
  logic [23:0]        shadow_step;
  logic               timeout_hit;

  assign state_dbg = state;

  // Mode wins over inc/dec; inc with dec cancels out.
  assign inc_eff = btn_inc && !btn_dec && !btn_mode;
  assign dec_eff = btn_dec && !btn_inc && !btn_mode;

  always_comb begin
    field_cur = shadow[SEC_LSB +: FIELD_W];
    field_max = MS_MAX;
    case (state)
      ST_SET_HR:  begin field_cur = shadow[HR_LSB  +: FIELD_W]; field_max = HR_MAX; end
      ST_SET_MIN: begin field_cur = shadow[MIN_LSB +: FIELD_W]; field_max = MS_MAX; end
      default:    ;
    endcase
  end

  bcd_field_step u_step (
    .field  (field_cur),
    .max    (field_max),
    .inc    (inc_eff),
    .dec    (dec_eff),
    .result (field_new)
  );

  always_comb begin
    shadow_step = shadow;
    case (state)
      ST_SET_HR:  shadow_step[HR_LSB  +: FIELD_W] = field_new;
      ST_SET_MIN: shadow_step[MIN_LSB +: FIELD_W] = field_new;
      ST_SET_SEC: shadow_step[SEC_LSB +: FIELD_W] = field_new;
      default:    ;
    endcase
  end

`ifdef RTC_SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] to_cnt;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_TICKS));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_TICKS);
  assign timeout_hit = 1'b0;
`endif

  function automatic logic [2:0] mask_for(input rtc_state_e st, input logic ph);
    case (st)
      ST_SET_HR:  return {ph, 2'b11};
      ST_SET_MIN: return {1'b1, ph, 1'b1};
      ST_SET_SEC: return {2'b11, ph};
      default:    return 3'b111;
    endcase
  endfunction

  // Every state entry and every inc/dec forces the phase visible, so the
  // mask is 3'b111 on those cycles; only a tick can dim the selected field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      shadow     <= '0;
      ld_time    <= '0;
      load       <= 1'b0;
      setting    <= 1'b0;
      blink_mask <= 3'b111;
      blink_ph   <= 1'b1;
`ifdef RTC_SET_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      load <= 1'b0;
      case (state)
        ST_RUN: begin
          blink_ph   <= 1'b1;
          blink_mask <= 3'b111;
`ifdef RTC_SET_TIMEOUT_EN
          to_cnt     <= '0;
`endif
          if (btn_mode) begin
            shadow  <= normalize_time(cur_time);
            ld_time <= normalize_time(cur_time);
            state   <= ST_SET_HR;
            setting <= 1'b1;
          end else begin
            ld_time <= cur_time;
          end
        end

        ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
`ifdef RTC_SET_TIMEOUT_EN
          if (btn_mode || btn_inc || btn_dec || timeout_hit) to_cnt <= '0;
          else if (tick_1hz)                                  to_cnt <= to_cnt + 1'b1;
`endif
          if (timeout_hit) begin
            state      <= ST_RUN;
            setting    <= 1'b0;
            ld_time    <= cur_time;
            blink_ph   <= 1'b1;
            blink_mask <= 3'b111;
          end else if (btn_mode) begin
            blink_ph   <= 1'b1;
            blink_mask <= 3'b111;
            ld_time    <= shadow;
            case (state)
              ST_SET_HR:  state <= ST_SET_MIN;
              ST_SET_MIN: state <= ST_SET_SEC;
              default: begin
                state <= ST_COMMIT;
                load  <= 1'b1;
              end
            endcase
          end else if (inc_eff || dec_eff) begin
            shadow     <= shadow_step;
            ld_time    <= shadow_step;
            blink_ph   <= 1'b1;
            blink_mask <= 3'b111;
          end else if (tick_1hz) begin
            blink_ph   <= ~blink_ph;
            blink_mask <= mask_for(state, ~blink_ph);
          end
        end

        ST_COMMIT: begin
          state      <= ST_RUN;
          setting    <= 1'b0;
          ld_time    <= cur_time;
          blink_ph   <= 1'b1;
          blink_mask <= 3'b111;
        end

        default: begin
          state   <= ST_RUN;
          setting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rtc_time_set_ctrl.md
RTC_TIME_SET_CTRL -- requirements
Module: rtc_time_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT_TICKS, default 10, number of 1 Hz ticks without a button press before set mode is abandoned (used only with RTC_SET_TIMEOUT_EN).
REQ-002 Port: clk  in  1  system clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: tick_1hz  in  1  single-cycle pulse, once per second, from the RTC seconds prescaler.
REQ-005 Port: btn_mode  in  1  single-cycle pulse, already debounced; enters set mode or advances the field.
REQ-006 Port: btn_inc  in  1  single-cycle pulse, already debounced; increments the selected field.
REQ-007 Port: btn_dec  in  1  single-cycle pulse, already debounced; decrements the selected field.
REQ-008 Port: cur_time  in  24  live RTC time, BCD {hr_m,hr_l,min_m,min_l,sec_m,sec_l}, 4 bits per digit.
REQ-009 Port: ld_time  out  24  shadow time in the same BCD packing; also drives the display while setting.
REQ-010 Port: load  out  1  single-cycle strobe; RTC shall copy ld_time into its counters.
REQ-011 Port: setting  out  1  high in every state except RUN; RTC display mux selects ld_time when high.
REQ-012 Port: blink_mask  out  3  {hr,min,sec}; a bit is 1 when that field is currently visible.

Function
REQ-013 FSM states: RUN, SET_HR, SET_MIN, SET_SEC, COMMIT.
REQ-014 RUN with btn_mode: the block captures cur_time into the shadow, enters SET_HR next cycle, and setting rises that same cycle.
REQ-015 Capture normalizes out-of-range fields: hour >23 becomes 00; minute or second >59 becomes 00; any digit >9 sets its field to 00.
REQ-016 SET_HR, SET_MIN, SET_SEC with btn_mode: advance to SET_MIN, SET_SEC, COMMIT respectively.
REQ-017 SET_x with btn_inc: selected field +1 in BCD; hour wraps 23->00; minute and second wrap 59->00; other fields unchanged.
REQ-018 SET_x with btn_dec: selected field -1 in BCD; hour wraps 00->23; minute and second wrap 00->59.
REQ-019 btn_inc and btn_dec in the same cycle: both ignored.
REQ-020 btn_mode together with btn_inc or btn_dec: mode is taken, inc and dec are ignored.
REQ-021 COMMIT: load=1 for exactly one cycle with ld_time equal to the shadow, then RUN; load is 0 in every other state.
REQ-022 Buttons in RUN other than btn_mode, and all buttons in COMMIT: ignored.
REQ-023 In RUN, ld_time tracks cur_time, registered with one cycle latency.
REQ-024 Blink phase toggles on each tick_1hz while setting is high.
REQ-025 Blink phase is forced to 1 (visible) on every state entry and on every inc/dec.
REQ-026 blink_mask: the selected field's bit equals the blink phase, other bits are 1; 3'b111 in RUN and COMMIT.

Reset
REQ-027 Asynchronous reset forces: state=RUN, shadow=24'h000000, ld_time=0, load=0, setting=0, blink_mask=3'b111, blink phase=1, timeout count=0.
REQ-028 Reset asserted mid-setting abandons the edit; no load pulse is issued on reset or after its release.

Configuration
REQ-029 Macro RTC_SET_TIMEOUT_EN defined: the block counts tick_1hz in SET_x states and clears the count on any button press or state change; count reaching TIMEOUT_TICKS returns to RUN next cycle with no load.
REQ-030 Macro RTC_SET_TIMEOUT_EN undefined: no timeout counter exists, and SET_x states are held indefinitely.

Structure
REQ-031 Package rtc_pkg shall hold: state enum, HR_MAX=23, MS_MAX=59, digit width 4, field bit positions within the 24-bit time word.
REQ-032 The design shall use one combinational sub-module, bcd_field_step (inputs: 8-bit BCD field, max, inc, dec; output: wrapped field), instantiated once and muxed to the selected field.

Verification
REQ-033 The bench shall apply cur_time=23:59:58, then mode, inc -> SET_HR, and check hr=00 while min and sec are unchanged.
REQ-034 The bench shall apply mode x2 in SET_HR, then dec at sec=00 -> sec=59; then mode -> exactly one load pulse with ld_time=24'h??_??_59, checking expected value.
REQ-035 The bench shall apply cur_time=24'h99_77_88, then mode -> shadow 00:00:00.
REQ-036 The bench shall pulse inc and dec in the same cycle and check that the field is unchanged, then pulse mode and inc in the same cycle and check that the state advances with the field unchanged.
REQ-037 The bench shall assert reset while in SET_MIN and check state RUN, setting=0, blink_mask=111, and no load pulse.
REQ-038 With RTC_SET_TIMEOUT_EN and TIMEOUT_TICKS=3, the bench shall enter SET_HR and send 3 ticks with no buttons, then check RUN, setting=0, load never asserted, and ld_time following cur_time again.
